// File: rtl/alu_ctrl_seq.sv
// Instruction-to-ALU-control sequencer: decodes one instruction into a registered
// control bundle and presents it with a valid/ready handshake; SLBI takes two beats.
module alu_ctrl_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  Oper,
    output logic        invA,
    output logic        invB,
    output logic        Cin,
    output logic        sign,
    output logic [2:0]  condition,
    output logic [1:0]  b_sel,
    output logic        a_prev,
    output logic        set_cond,
    output logic        last,
    output logic        err
);

    // state  | meaning
    // EMPTY  | nothing held, ready for an instruction
    // BEAT0  | first (or only) beat of the held instruction on the output
    // BEAT1  | second beat of SLBI on the output
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] oper;
        logic       inv_a;
        logic       inv_b;
        logic       cin;
        logic       sign;
        logic [2:0] cond;
        logic [1:0] b_sel;
        logic       a_prev;
        logic       set_cond;
        logic       last;
        logic       err;
    } bundle_t;

    localparam logic [4:0] OP_ALU   = 5'b11011;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;
    localparam logic [4:0] OP_SLBI  = 5'b10010;

    function automatic bundle_t decode_beat0(input logic [4:0] opcode, input logic [1:0] funct);
        bundle_t b;
        b      = '0;
        b.last = 1'b1;
        case (opcode)
            OP_ALU: begin
                case (funct)
                    2'b00: b.oper = 3'b100;
                    2'b01: begin
                        b.oper  = 3'b100;
                        b.inv_a = 1'b1;
                        b.cin   = 1'b1;
                    end
                    2'b10: b.oper = 3'b111;
                    default: begin
                        b.oper  = 3'b101;
                        b.inv_b = 1'b1;
                    end
                endcase
            end
            OP_SHIFT: b.oper = {1'b0, funct};
            OP_ADDI: begin
                b.oper  = 3'b100;
                b.b_sel = 2'b01;
            end
            OP_SEQ, OP_SLT, OP_SLE: begin
                b.oper     = 3'b100;
                b.inv_b    = 1'b1;
                b.cin      = 1'b1;
                b.sign     = 1'b1;
                b.set_cond = 1'b1;
                b.cond     = (opcode == OP_SEQ) ? 3'b000 :
                             (opcode == OP_SLT) ? 3'b010 : 3'b001;
            end
            OP_SCO: begin
                b.oper     = 3'b100;
                b.set_cond = 1'b1;
                b.cond     = 3'b011;
            end
            OP_SLBI: begin
                b.oper  = 3'b001;
                b.b_sel = 2'b11;
                b.last  = 1'b0;
            end
            default: b.err = 1'b1;
        endcase
        return b;
    endfunction

    // SLBI second beat: OR the shifted previous result with zero-extended imm8
    function automatic bundle_t slbi_beat1();
        bundle_t b;
        b        = '0;
        b.oper   = 3'b110;
        b.b_sel  = 2'b10;
        b.a_prev = 1'b1;
        b.last   = 1'b1;
        return b;
    endfunction

    state_t      state_q, state_d;
    bundle_t     bundle_q, bundle_d;
    logic [15:0] instr_q, instr_d;
    logic        capture;
    logic        two_beat;

    assign two_beat = (instr_q[15:11] == OP_SLBI);

    always_comb begin
        state_d  = state_q;
        bundle_d = bundle_q;
        instr_d  = instr_q;
        in_ready = 1'b0;
        capture  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                in_ready = 1'b1;
                capture  = in_valid;
            end
            S_BEAT0: begin
                if (out_ready) begin
                    if (two_beat) begin
                        state_d  = S_BEAT1;
                        bundle_d = slbi_beat1();
                    end else begin
                        in_ready = 1'b1;
                        capture  = in_valid;
                        if (!in_valid) begin
                            state_d  = S_EMPTY;
                            bundle_d = '0;
                        end
                    end
                end
            end
            S_BEAT1: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    capture  = in_valid;
                    if (!in_valid) begin
                        state_d  = S_EMPTY;
                        bundle_d = '0;
                    end
                end
            end
            default: begin
                state_d  = S_EMPTY;
                bundle_d = '0;
            end
        endcase
        if (capture) begin
            instr_d  = instr;
            bundle_d = decode_beat0(instr[15:11], instr[1:0]);
            state_d  = S_BEAT0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            bundle_q <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            bundle_q <= bundle_d;
            instr_q  <= instr_d;
        end
    end

    // Only the opcode field is needed after capture; the rest is kept for visibility.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_q[10:0];

    assign out_valid = (state_q != S_EMPTY);
    assign Oper      = bundle_q.oper;
    assign invA      = bundle_q.inv_a;
    assign invB      = bundle_q.inv_b;
    assign Cin       = bundle_q.cin;
    assign sign      = bundle_q.sign;
    assign condition = bundle_q.cond;
    assign b_sel     = bundle_q.b_sel;
    assign a_prev    = bundle_q.a_prev;
    assign set_cond  = bundle_q.set_cond;
    assign last      = bundle_q.last;
    assign err       = bundle_q.err;

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  upstream instruction valid.
REQ-004 in_ready  output  1  block can accept an instruction this cycle (combinational from state and out_ready).
REQ-005 instr  input  16  instruction; opcode instr[15:11], funct instr[1:0], imm8 instr[7:0].
REQ-006 out_valid  output  1  ALU control bundle valid.
REQ-007 out_ready  input  1  downstream ALU stage accepts bundle.
REQ-008 Oper  output  3  ALU operation: 000 rotl, 001 shl, 010 sra, 011 srl, 100 add, 101 and, 110 or, 111 xor.
REQ-009 invA, invB, Cin, sign  output  1 each  ALU operand/carry/sign controls.
REQ-010 condition  output  3  ALU condition select (000 ==0, 001 <=, 010 <, 011 carry, 1xx !=0).
REQ-011 b_sel  output  2  ALU B source: 00 Rt, 01 sign-ext imm8, 10 zero-ext imm8, 11 constant 8.
REQ-012 a_prev  output  1  ALU A source is the previous ALU result.
REQ-013 set_cond  output  1  writeback takes condition_true, not Out.
REQ-014 last  output  1  final beat of the instruction.
REQ-015 err  output  1  undefined opcode/funct.

Function
REQ-016 Decode table (unlisted controls 0, b_sel 00, last 1):
- 11011 funct 00 ADD: Oper 100.
- 11011 funct 01 SUB: Oper 100, invA, Cin.
- 11011 funct 10 XOR: Oper 111.
- 11011 funct 11 ANDN: Oper 101, invB.
- 11010 funct ff: shift, Oper = {1'b0, ff}.
- 01000 ADDI: Oper 100, b_sel 01.
- 11100 SEQ / 11101 SLT / 11110 SLE: Oper 100, invB, Cin, sign, set_cond; condition 000 / 010 / 001 respectively.
- 11111 SCO: Oper 100, set_cond, condition 011.
- 10010 SLBI: two beats; beat 0 = Oper 001, b_sel 11, last 0; beat 1 = Oper 110, b_sel 10, a_prev 1, last 1.
- Any other opcode: err 1, all other controls 0, single beat.
REQ-017 State machine: EMPTY, BEAT0, BEAT1.
REQ-018 EMPTY: out_valid 0; in_ready 1; on in_valid, capture instr and go to BEAT0.
REQ-019 BEAT0: out_valid 1, beat-0 controls. On out_ready: two-beat instruction -> BEAT1; single-beat instruction -> capture new instr and stay in BEAT0 if in_valid, else EMPTY.
REQ-020 BEAT1: out_valid 1, beat-1 controls. On out_ready: capture new instr and go to BEAT0 if in_valid, else EMPTY.
REQ-021 in_ready = EMPTY | (BEAT0 & single-beat & out_ready) | (BEAT1 & out_ready).
REQ-022 Latency: instruction accepted in cycle N presents its bundle with out_valid=1 in cycle N+1.
REQ-023 Throughput: one single-beat instruction per cycle under continuous in_valid and out_ready; SLBI occupies two output cycles.
REQ-024 While out_valid=1 and out_ready=0, all outputs stay constant and in_ready=0.
REQ-025 All bundle outputs are registered (decoded at capture, not from live instr).
REQ-026 in_valid in BEAT0 of a two-beat instruction is ignored; no capture occurs.

Reset
REQ-027 rst=1 forces state EMPTY and clears out_valid, Oper, invA, invB, Cin, sign, condition, b_sel, a_prev, set_cond, last, err and the instr register to 0, overriding any handshake in the same cycle.
REQ-028 rst asserted in BEAT0 or BEAT1 discards the pending instruction; no beat is emitted after reset deasserts until a new capture.

Verification
REQ-029 ADD 0xD800 accepted, out_ready=1 -> next cycle out_valid=1, Oper=100, invA=invB=Cin=0, last=1, err=0; then EMPTY.
REQ-030 SUB 0xD801 followed back-to-back by XOR 0xD802, out_ready=1 -> bundles on consecutive cycles: (Oper 100, invA 1, Cin 1), then (Oper 111); in_ready stays 1.
REQ-031 SLBI 0x90A5 -> beat 0 Oper=001, b_sel=11, last=0; beat 1 Oper=110, b_sel=10, a_prev=1, last=1; in_ready=0 during beat 0.
REQ-032 SLT 0xE800 with out_ready=0 for 3 cycles -> bundle (Oper 100, invB, Cin, sign, set_cond, condition=010) held stable, in_ready=0; released on the first out_ready=1 cycle.
REQ-033 Undefined opcode 0x0000 -> out_valid=1, err=1, all other controls 0, last=1.
REQ-034 rst pulsed during SLBI beat 1 -> next cycle out_valid=0, all outputs 0, in_ready=1.
